// File: rtl/pipelined_logic_reducer.sv
// Per-lane logic reduction (AND/OR/XOR/NAND) carried through an elastic
// valid/ready pipeline with full backpressure and a delivered-result counter.
module pipelined_logic_reducer #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned STAGES   = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CHANNELS*WIDTH-1:0]   in_data,
   input  logic [1:0]                  in_mode,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CHANNELS-1:0]         out_lane,
   output logic                        out_all,
   output logic [CNT_W-1:0]            out_count
);

   localparam int unsigned LAST = STAGES - 1;
   localparam int unsigned DW   = CHANNELS + 1;

   // Reduce one lane under the selected function
   function automatic logic reduce_lane(input logic [WIDTH-1:0] v, input logic [1:0] m);
      logic r;
      case (m)
         2'b00:   r = &v;
         2'b01:   r = |v;
         2'b10:   r = ^v;
         default: r = ~&v;
      endcase
      return r;
   endfunction

   logic [CHANNELS-1:0] red_lane;
   logic [DW-1:0]       red_word;
   logic [STAGES-1:0]   stg_vld;
   logic [STAGES-1:0]   stg_adv;
   logic [STAGES-1:0]   stg_take;
   logic [DW-1:0]       stg_dat [STAGES];
   logic [DW-1:0]       stg_src [STAGES];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      assign red_lane[c] = reduce_lane(in_data[c*WIDTH +: WIDTH], in_mode);
   end

   // The AND-of-lanes bit rides with the beat so the last stage presents it registered
   assign red_word = {&red_lane, red_lane};

   // A stage advances when it holds a beat and some stage above it is empty or the sink takes
   always_comb begin
      logic room;
      room    = out_ready;
      stg_adv = '0;
      for (int k = int'(LAST); k >= 0; k--) begin
         stg_adv[k] = stg_vld[k] & room;
         room       = room | ~stg_vld[k];
      end
   end

   assign in_ready = ~stg_vld[0] | stg_adv[0];

   // Source of each stage: the reducer for stage 0, the stage below otherwise
   always_comb begin
      stg_take    = '0;
      stg_take[0] = in_valid & in_ready;
      stg_src[0]  = red_word;
      for (int k = 1; k < int'(STAGES); k++) begin
         stg_take[k] = stg_adv[k-1];
         stg_src[k]  = stg_dat[k-1];
      end
   end

   // Stage registers: load when empty or advancing, hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_vld <= '0;
         for (int k = 0; k < int'(STAGES); k++) stg_dat[k] <= '0;
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (!stg_vld[k] || stg_adv[k]) begin
               stg_vld[k] <= stg_take[k];
               if (stg_take[k]) stg_dat[k] <= stg_src[k];
            end
         end
      end
   end

   // Count completed output handshakes, wrapping silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_count <= '0;
      else if (stg_vld[LAST] && out_ready) out_count <= out_count + CNT_W'(1);
   end

   assign out_valid = stg_vld[LAST];
   assign out_lane  = stg_dat[LAST][CHANNELS-1:0];
   assign out_all   = stg_dat[LAST][CHANNELS];

endmodule

// File: tb/tb_pipelined_logic_reducer.sv
// Directed testbench for pipelined_logic_reducer (WIDTH=8, CHANNELS=2, STAGES=2, CNT_W=4).
module tb_pipelined_logic_reducer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_lane;
   logic        out_all;
   logic [3:0]  out_count;

   int errors = 0;
   int checks = 0;

   pipelined_logic_reducer #(.WIDTH(8), .CHANNELS(2), .STAGES(2), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane(out_lane), .out_all(out_all), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b1;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_lane !== 2'b00) begin errors++; $display("FAIL reset_out_lane: got %b expected 00", out_lane); end
      checks++; if (out_all !== 1'b0) begin errors++; $display("FAIL reset_out_all: got %b expected 0", out_all); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_beat();
      in_valid = 1'b1; in_data = 16'hFF0F; in_mode = 2'b00;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got out_valid=%b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (out_lane !== 2'b10) begin errors++; $display("FAIL single_lane: got %b expected 10", out_lane); end
      checks++; if (out_all !== 1'b0) begin errors++; $display("FAIL single_all: got %b expected 0", out_all); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got out_valid=%b expected 0", out_valid); end
      checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", out_count); end
   endtask

   task automatic test_mode_sweep();
      logic [1:0] modes [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [1:0] lanes [4] = '{2'b00, 2'b11, 2'b11, 2'b11};
      logic       alls  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      for (int n = 0; n <= 4; n++) begin
         if (n < 4) begin in_valid = 1'b1; in_data = 16'h8007; in_mode = modes[n]; end
         else in_valid = 1'b0;
         #1;
         if (n < 4) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready[%0d]: got %b expected 1", n, in_ready); end
         end
         tick();
         if (n == 0) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_early: got out_valid=%b expected 0", out_valid); end
         end else begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid[%0d]: got %b expected 1", n-1, out_valid); end
            checks++; if (out_lane !== lanes[n-1]) begin errors++; $display("FAIL sweep_lane[%0d]: got %b expected %b", n-1, out_lane, lanes[n-1]); end
            checks++; if (out_all !== alls[n-1]) begin errors++; $display("FAIL sweep_all[%0d]: got %b expected %b", n-1, out_all, alls[n-1]); end
         end
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drained: got out_valid=%b expected 0", out_valid); end
      checks++; if (out_count !== 4'd5) begin errors++; $display("FAIL sweep_count: got %0d expected 5", out_count); end
   endtask

   task automatic test_backpressure();
      logic [15:0] bd [4] = '{16'hFFFF, 16'h0001, 16'h0103, 16'hFFFF};
      logic [1:0]  bm [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [1:0]  bl [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
      logic        ba [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      int acc = 0;
      int got = 0;
      logic fire_in, fire_out;
      out_ready = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (n >= 5) out_ready = 1'b1;
         in_valid = (acc < 4);
         if (acc < 4) begin in_data = bd[acc]; in_mode = bm[acc]; end
         #1;
         fire_in  = in_valid & in_ready;
         fire_out = out_valid & out_ready;
         if (n == 2) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop: got %b expected 0", in_ready); end
            checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepts_before_full: got %0d expected 2", acc); end
         end
         if (n >= 2 && n <= 4) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", n, out_valid); end
            checks++; if (out_lane !== 2'b11) begin errors++; $display("FAIL bp_hold_lane[%0d]: got %b expected 11", n, out_lane); end
            checks++; if (out_all !== 1'b1) begin errors++; $display("FAIL bp_hold_all[%0d]: got %b expected 1", n, out_all); end
         end
         if (fire_out) begin
            if (got < 4) begin
               checks++; if (out_lane !== bl[got]) begin errors++; $display("FAIL bp_order_lane[%0d]: got %b expected %b", got, out_lane, bl[got]); end
               checks++; if (out_all !== ba[got]) begin errors++; $display("FAIL bp_order_all[%0d]: got %b expected %b", got, out_all, ba[got]); end
            end
         end
         tick();
         if (fire_in) acc++;
         if (fire_out) got++;
      end
      in_valid = 1'b0;
      checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
      checks++; if (got != 4) begin errors++; $display("FAIL bp_delivered: got %0d expected 4", got); end
      checks++; if (out_count !== 4'd9) begin errors++; $display("FAIL bp_count: got %0d expected 9", out_count); end
   endtask

   // Beat i carries lane0 = i[0] and lane1 = i[1] under AND
   function automatic logic [15:0] full_data(input int i);
      logic [1:0] b;
      b = 2'(i);
      return {b[1] ? 8'hFF : 8'h00, b[0] ? 8'hFF : 8'h00};
   endfunction

   task automatic test_back_to_back();
      logic [1:0] exp_lane;
      in_mode = 2'b00; out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = full_data(i);
         tick();
      end
      out_ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         in_valid = (n < 10);
         in_data  = full_data(n + 2);
         #1;
         exp_lane = 2'(n);
         if (n < 10) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", n, in_ready); end
         end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", n, out_valid); end
         checks++; if (out_lane !== exp_lane) begin errors++; $display("FAIL b2b_lane[%0d]: got %b expected %b", n, out_lane, exp_lane); end
         checks++; if (out_all !== (&exp_lane)) begin errors++; $display("FAIL b2b_all[%0d]: got %b expected %b", n, out_all, &exp_lane); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got out_valid=%b expected 0", out_valid); end
      checks++; if (out_count !== 4'd5) begin errors++; $display("FAIL b2b_count: got %0d expected 5 (21 mod 16)", out_count); end
   endtask

   task automatic test_async_reset();
      in_mode = 2'b00; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'hFFFF;
      tick();
      in_data = 16'hFF00;
      tick();
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", out_count); end
      checks++; if (out_lane !== 2'b00) begin errors++; $display("FAIL arst_lane: got %b expected 00", out_lane); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
      @(negedge clk) rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_stale[%0d]: got out_valid=%b expected 0", n, out_valid); end
      end
      in_valid = 1'b1; in_data = 16'h0FFF;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_post_early: got %b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_post_valid: got %b expected 1", out_valid); end
      checks++; if (out_lane !== 2'b01) begin errors++; $display("FAIL arst_post_lane: got %b expected 01", out_lane); end
      tick();
      checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL arst_post_count: got %0d expected 1", out_count); end
   endtask

   task automatic test_counter_wrap();
      int hs = 0;
      logic fire_out;
      logic [3:0] exp_cnt;
      #3 rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      out_ready = 1'b1; in_mode = 2'b01; in_data = 16'h0100;
      for (int n = 0; n < 23; n++) begin
         in_valid = (n < 17);
         #1;
         fire_out = out_valid & out_ready;
         tick();
         if (fire_out) begin
            hs++;
            exp_cnt = 4'(hs);
            checks++; if (out_count !== exp_cnt) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", hs, out_count, exp_cnt); end
         end
      end
      in_valid = 1'b0;
      checks++; if (hs != 17) begin errors++; $display("FAIL wrap_handshakes: got %0d expected 17", hs); end
      checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL wrap_final: got %0d expected 1", out_count); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_mode_sweep();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      test_counter_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
